// File: rtl/core_pkg.sv
// Shared core types for the lane array and the store path.
// Provides lane count, VRF data word, instruction ID, the store beat-count
// type and the store_gather FSM state enum.
package core_pkg;

  localparam int NrLane   = 4;
  localparam int LenWidth = 16;

  typedef logic [31:0]         vrf_data_t;
  typedef logic [7:0]          insn_id_t;
  typedef logic [LenWidth-1:0] store_len_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } store_gather_state_e;

endpackage

// File: rtl/store_op_fifo.sv
// Per-lane store operand FIFO. Synchronous, no fall-through: a word pushed
// in cycle t is at the head in t+1. Storage is cleared at reset so an empty
// FIFO reads zero until its first write.
// Ports: clk_i/rst_i (sync active-high), push_i/data_i (ignored when full),
// pop_i (ignored when empty), data_o (head), full_o, empty_o.
module store_op_fifo #(
  parameter int  Depth  = 2,
  parameter type data_t = logic [31:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(Depth);

  data_t [Depth-1:0] mem_q, mem_d;
  logic  [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic  [AW:0]      cnt_q, cnt_d;
  logic              push, pop;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  assign push = push_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + 1'b1;  // Depth is a power of two: pointer wraps naturally
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/store_gather.sv
// Store operand gather. Buffers each lane's store operand in its own FIFO
// and, while a store instruction is active, emits one full-width beat each
// time every lane has an operand at its head. Counts beats down, flags the
// last one and pulses done_o with the instruction ID after its handshake.
// Ports: clk_i/rst_i (sync active-high); store_req_* request handshake with
// store_len_i (beats-1) and store_id_i; store_op_* per-lane operand inputs;
// beat_* gathered output handshake with last flag and ID; done_o/done_id_o.
module store_gather
  import core_pkg::*;
#(
  parameter int Depth    = 2,
  parameter int LenWidth = core_pkg::LenWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      store_req_valid_i,
  output logic                      store_req_ready_o,
  input  logic [LenWidth-1:0]       store_len_i,
  input  insn_id_t                  store_id_i,
  input  logic [NrLane-1:0]         store_op_valid_i,
  output logic [NrLane-1:0]         store_op_ready_o,
  input  vrf_data_t [NrLane-1:0]    store_op_i,
  output logic                      beat_valid_o,
  input  logic                      beat_ready_i,
  output vrf_data_t [NrLane-1:0]    beat_o,
  output logic                      beat_last_o,
  output insn_id_t                  beat_id_o,
  output logic                      done_o,
  output insn_id_t                  done_id_o
);

  logic [NrLane-1:0]      full, empty;
  vrf_data_t [NrLane-1:0] head;

  store_gather_state_e    state_q, state_d;
  logic [LenWidth-1:0]    remaining_q, remaining_d;
  insn_id_t               id_q, id_d, done_id_q, done_id_d;
  logic                   done_q, done_d;
  logic                   hs;

  // All lanes pop together on the beat handshake, so heads stay aligned.
  for (genvar l = 0; l < NrLane; l++) begin : g_lane
    store_op_fifo #(
      .Depth  (Depth),
      .data_t (vrf_data_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (store_op_valid_i[l]),
      .data_i  (store_op_i[l]),
      .pop_i   (hs),
      .data_o  (head[l]),
      .full_o  (full[l]),
      .empty_o (empty[l])
    );
  end

  assign store_op_ready_o  = ~full;
  assign store_req_ready_o = (state_q == IDLE);
  assign beat_valid_o      = (state_q == ACTIVE) && (&(~empty));
  assign beat_last_o       = (state_q == ACTIVE) && (remaining_q == '0);
  assign beat_o            = head;
  assign beat_id_o         = id_q;
  assign done_o            = done_q;
  assign done_id_o         = done_id_q;
  assign hs                = beat_valid_o & beat_ready_i;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    id_d        = id_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    case (state_q)
      IDLE: begin
        if (store_req_valid_i) begin
          remaining_d = store_len_i;
          id_d        = store_id_i;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (hs) begin
          if (remaining_q == '0) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            done_id_d = id_q;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      id_q        <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      id_q        <= id_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
    end
  end

endmodule

// File: tb/tb_store_gather.sv
module tb_store_gather;
  import core_pkg::*;

  localparam int VW = $bits(vrf_data_t);
  localparam int BW = NrLane * VW;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   store_req_valid_i;
  logic                   store_req_ready_o;
  logic [15:0]            store_len_i;
  insn_id_t               store_id_i;
  logic [NrLane-1:0]      store_op_valid_i;
  logic [NrLane-1:0]      store_op_ready_o;
  vrf_data_t [NrLane-1:0] store_op_i;
  logic                   beat_valid_o;
  logic                   beat_ready_i;
  vrf_data_t [NrLane-1:0] beat_o;
  logic                   beat_last_o;
  insn_id_t               beat_id_o;
  logic                   done_o;
  insn_id_t               done_id_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  store_gather #(.Depth(2), .LenWidth(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .store_req_valid_i (store_req_valid_i),
    .store_req_ready_o (store_req_ready_o),
    .store_len_i       (store_len_i),
    .store_id_i        (store_id_i),
    .store_op_valid_i  (store_op_valid_i),
    .store_op_ready_o  (store_op_ready_o),
    .store_op_i        (store_op_i),
    .beat_valid_o      (beat_valid_o),
    .beat_ready_i      (beat_ready_i),
    .beat_o            (beat_o),
    .beat_last_o       (beat_last_o),
    .beat_id_o         (beat_id_o),
    .done_o            (done_o),
    .done_id_o         (done_id_o)
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane l carries base+l.
  function automatic logic [BW-1:0] beat_of(input int base);
    vrf_data_t [NrLane-1:0] b;
    for (int l = 0; l < NrLane; l++) b[l] = vrf_data_t'(base + l);
    return b;
  endfunction

  task automatic set_ops(input logic [NrLane-1:0] v, input int base);
    store_op_valid_i = v;
    for (int l = 0; l < NrLane; l++) store_op_i[l] = vrf_data_t'(base + l);
  endtask

  task automatic req(input logic [15:0] len, input insn_id_t id);
    store_req_valid_i = 1'b1;
    store_len_i       = len;
    store_id_i        = id;
  endtask

  task automatic quiet();
    store_req_valid_i = 1'b0;
    store_op_valid_i  = '0;
  endtask

  initial begin
    int sent [NrLane];
    int nb, nd;
    rst_i = 1'b1;
    store_req_valid_i = 1'b0;
    store_len_i = '0;
    store_id_i = '0;
    store_op_valid_i = '0;
    store_op_i = '0;
    beat_ready_i = 1'b1;

    // ---- reset state
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", 128'(store_req_ready_o), 128'(1));
    chk("rst_op_ready", 128'(store_op_ready_o), 128'(4'hF));
    chk("rst_beat_valid", 128'(beat_valid_o), 128'(0));
    chk("rst_beat_last", 128'(beat_last_o), 128'(0));
    chk("rst_beat", beat_o, '0);
    chk("rst_beat_id", 128'(beat_id_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_done_id", 128'(done_id_o), 128'(0));
    rst_i = 1'b0;

    // ---- single beat, len=0
    req(16'd0, 8'h03);
    set_ops('1, 'hA0);
    @(negedge clk_i);
    quiet();
    chk("t1_valid", 128'(beat_valid_o), 128'(1));
    chk("t1_beat", beat_o, beat_of('hA0));
    chk("t1_last", 128'(beat_last_o), 128'(1));
    chk("t1_beat_id", 128'(beat_id_o), 128'(8'h03));
    chk("t1_req_ready_busy", 128'(store_req_ready_o), 128'(0));
    @(negedge clk_i);
    chk("t1_done", 128'(done_o), 128'(1));
    chk("t1_done_id", 128'(done_id_o), 128'(8'h03));
    chk("t1_req_ready", 128'(store_req_ready_o), 128'(1));
    chk("t1_valid_after", 128'(beat_valid_o), 128'(0));
    @(negedge clk_i);
    chk("t1_done_pulse", 128'(done_o), 128'(0));

    // ---- len=3, lane l starts l cycles late, each lane sends 4 operands
    for (int l = 0; l < NrLane; l++) sent[l] = 0;
    nb = 0;
    nd = 0;
    req(16'd3, 8'h21);
    for (int c = 0; c < 30; c++) begin
      if (c > 0) store_req_valid_i = 1'b0;
      for (int l = 0; l < NrLane; l++) begin
        store_op_valid_i[l] = (c >= l) && (sent[l] < 4);
        store_op_i[l] = vrf_data_t'('h100 * sent[l] + l);
        if (store_op_valid_i[l] && store_op_ready_o[l]) sent[l]++;
      end
      @(negedge clk_i);
      if (beat_valid_o && beat_ready_i) begin
        chk("t2_beat", beat_o, beat_of('h100 * nb));
        chk("t2_last", 128'(beat_last_o), 128'(nb == 3));
        nb++;
      end
      if (done_o) begin
        chk("t2_done_id", 128'(done_id_o), 128'(8'h21));
        nd++;
      end
    end
    quiet();
    chk("t2_nbeats", 128'(nb), 128'(4));
    chk("t2_ndone", 128'(nd), 128'(1));

    // ---- fill all FIFOs while IDLE
    set_ops('1, 'h30);
    @(negedge clk_i);
    set_ops('1, 'h40);
    @(negedge clk_i);
    quiet();
    chk("t3_op_ready_full", 128'(store_op_ready_o), 128'(0));
    chk("t3_valid_idle", 128'(beat_valid_o), 128'(0));
    @(negedge clk_i);
    chk("t3_still_full", 128'(store_op_ready_o), 128'(0));
    req(16'd1, 8'h07);
    @(negedge clk_i);
    quiet();
    chk("t3_b0", beat_o, beat_of('h30));
    chk("t3_b0_last", 128'(beat_last_o), 128'(0));
    @(negedge clk_i);
    chk("t3_b1_valid", 128'(beat_valid_o), 128'(1));
    chk("t3_b1", beat_o, beat_of('h40));
    chk("t3_b1_last", 128'(beat_last_o), 128'(1));
    chk("t3_ready_back", 128'(store_op_ready_o), 128'(4'hF));
    @(negedge clk_i);
    chk("t3_done", 128'(done_o), 128'(1));
    chk("t3_done_id", 128'(done_id_o), 128'(8'h07));
    chk("t3_empty", 128'(beat_valid_o), 128'(0));

    // ---- back-pressure: hold beat_ready low 5 cycles
    beat_ready_i = 1'b0;
    req(16'd0, 8'h09);
    set_ops('1, 'h50);
    @(negedge clk_i);
    quiet();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 128'(beat_valid_o), 128'(1));
      chk("t4_hold_beat", beat_o, beat_of('h50));
      chk("t4_hold_last", 128'(beat_last_o), 128'(1));
      chk("t4_hold_done", 128'(done_o), 128'(0));
      if (i < 4) @(negedge clk_i);
    end
    beat_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t4_done", 128'(done_o), 128'(1));
    chk("t4_done_id", 128'(done_id_o), 128'(8'h09));

    // ---- reset after 2 of 4 beats
    @(negedge clk_i);
    req(16'd3, 8'h04);
    set_ops('1, 'h600);
    @(negedge clk_i);
    store_req_valid_i = 1'b0;
    chk("t5_b0", beat_o, beat_of('h600));
    set_ops('1, 'h610);
    @(negedge clk_i);
    chk("t5_b1", beat_o, beat_of('h610));
    set_ops('1, 'h620);
    @(negedge clk_i);
    quiet();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t5_req_ready", 128'(store_req_ready_o), 128'(1));
    chk("t5_valid", 128'(beat_valid_o), 128'(0));
    chk("t5_op_ready", 128'(store_op_ready_o), 128'(4'hF));
    chk("t5_beat_clr", beat_o, '0);
    chk("t5_done", 128'(done_o), 128'(0));
    @(negedge clk_i);
    chk("t5_done_late", 128'(done_o), 128'(0));
    req(16'd0, 8'h02);
    set_ops('1, 'h70);
    @(negedge clk_i);
    quiet();
    chk("t5_new_beat", beat_o, beat_of('h70));
    chk("t5_new_last", 128'(beat_last_o), 128'(1));
    @(negedge clk_i);
    chk("t5_new_done", 128'(done_o), 128'(1));
    chk("t5_new_done_id", 128'(done_id_o), 128'(8'h02));

    // ---- back-to-back requests, IDs 5 then 6
    @(negedge clk_i);
    req(16'd1, 8'h05);
    set_ops('1, 'hB0);
    @(negedge clk_i);
    chk("t6_b0", beat_o, beat_of('hB0));
    chk("t6_b0_id", 128'(beat_id_o), 128'(8'h05));
    chk("t6_busy", 128'(store_req_ready_o), 128'(0));
    req(16'd0, 8'h06);
    set_ops('1, 'hC0);
    @(negedge clk_i);
    chk("t6_b1", beat_o, beat_of('hC0));
    chk("t6_b1_last", 128'(beat_last_o), 128'(1));
    chk("t6_busy_last", 128'(store_req_ready_o), 128'(0));
    set_ops('1, 'hD0);
    @(negedge clk_i);
    store_op_valid_i = '0;
    chk("t6_done5", 128'(done_o), 128'(1));
    chk("t6_done_id5", 128'(done_id_o), 128'(8'h05));
    chk("t6_accept", 128'(store_req_ready_o), 128'(1));
    chk("t6_gap_valid", 128'(beat_valid_o), 128'(0));
    @(negedge clk_i);
    quiet();
    chk("t6_b2", beat_o, beat_of('hD0));
    chk("t6_b2_id", 128'(beat_id_o), 128'(8'h06));
    chk("t6_b2_last", 128'(beat_last_o), 128'(1));
    chk("t6_no_done", 128'(done_o), 128'(0));
    @(negedge clk_i);
    chk("t6_done6", 128'(done_o), 128'(1));
    chk("t6_done_id6", 128'(done_id_o), 128'(8'h06));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_gather.md
# store_gather

Downstream of the lane array's store-operand outputs. Buffers each lane's store operand in a small per-lane FIFO and, for the store instruction currently granted, emits one full-width beat whenever every lane has an operand ready. Counts beats, flags the last one, and pulses a done signal with the instruction ID, so the store unit sees lane-aligned data and a single completion event.

## Interface
- `Depth`, 2: entries per lane FIFO (≥2, power of two).
- `LenWidth`, 16: width of the beat-count field.
- `NrLane`, `vrf_data_t`, `insn_id_t`: taken from `core_pkg`.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: reset; synchronous, active-high.
- `store_req_valid_i` in 1: new store instruction request.
- `store_req_ready_o` out 1: accepted only in IDLE.
- `store_len_i` in LenWidth: number of beats minus 1.
- `store_id_i` in insn_id_t: instruction ID.
- `store_op_valid_i` in NrLane: per-lane operand valid.
- `store_op_ready_o` out NrLane: per-lane FIFO not full.
- `store_op_i` in NrLane×vrf_data_t: per-lane operand.
- `beat_valid_o` out 1: gathered beat valid.
- `beat_ready_i` in 1: store unit accepts beat.
- `beat_o` out NrLane×vrf_data_t: lane l's data in slot l.
- `beat_last_o` out 1: current beat is the final beat of the instruction.
- `beat_id_o` out insn_id_t: ID of the active instruction.
- `done_o` out 1: one-cycle pulse after the last beat handshake.
- `done_id_o` out insn_id_t: ID qualifying `done_o`.

## Operation
- Per-lane FIFO push on `store_op_valid_i[l] & store_op_ready_o[l]`. `store_op_ready_o[l]` is `!full[l]` and is independent of FSM state, so operands may arrive before the request.
- FSM states:
  - IDLE: `store_req_ready_o=1`. On `store_req_valid_i`, latch `remaining=store_len_i` and `id=store_id_i`, then go to ACTIVE.
  - ACTIVE: `beat_valid_o = &(~empty)`. `beat_last_o = (remaining==0)`.
- Beat handshake (`beat_valid_o & beat_ready_i`):
  - Pop every lane FIFO in the same cycle.
  - If `remaining==0`: go to IDLE and register `done_o=1`, `done_id_o=id` for the next cycle.
  - Otherwise decrement `remaining`.
- A lane never pops alone; lanes stay aligned by construction.
- `beat_valid_o` must not depend on `beat_ready_i`. Once asserted, `beat_o` is held stable until the handshake.
- Operands arriving during IDLE stay buffered. A lane that fills blocks only its own input.
- Length field: `store_len_i=0` means 1 beat. The maximum is 2^LenWidth beats. `remaining` does not wrap: a decrement happens only when it is non-zero.
- A new request is not accepted in the cycle of the last handshake; earliest acceptance is the following cycle (IDLE).

## Timing
- Reset values:
  - FSM in IDLE; FIFOs empty; `remaining=0`, `id=0`.
  - `store_req_ready_o=1`, `store_op_ready_o='1`.
  - `beat_valid_o=0`, `beat_last_o=0`, `beat_o=0` (reads empty storage cleared at reset).
  - `beat_id_o=0`, `done_o=0`, `done_id_o=0`.
- FIFO latency: an operand pushed in cycle t is visible at the FIFO head in t+1. There is no fall-through.
- Throughput: with Depth=2 and continuous inputs, one beat per cycle.
- Push on a full FIFO is impossible because ready is low. Push and pop in the same cycle on a non-full FIFO keeps occupancy unchanged.
- Request accepted at t: `beat_valid_o` can first be 1 at t+1, if all FIFOs are non-empty.
- Last handshake at t: `done_o=1` at t+1 only; `store_req_ready_o=1` at t+1.
- Reset asserted mid-instruction: all state returns to reset values at the next edge. Buffered operands are discarded and no `done_o` is produced.

## Structure
- `core_pkg` gains `store_len_t` (LenWidth bits) and the state enum `store_gather_state_e` {IDLE, ACTIVE}. `vrf_data_t`, `insn_id_t` and `NrLane` already live there.
- Sub-module: `store_op_fifo`, a parameterised synchronous FIFO (Depth, data type) with `full`/`empty` flags, instantiated NrLane times in a generate loop.
- The gather FSM, beat counter and done register live in the top level.

## Test plan
- Reset, then NrLane=4, len=0, all lanes push 0xA0+l in one cycle, `beat_ready_i=1` → one beat with slot l=0xA0+l and `beat_last_o=1`; `done_o` pulses one cycle later with the request ID.
- len=3, lanes push 4 operands each with staggered skew (lane l delayed l cycles) → exactly 4 beats in lane-aligned order; `beat_last_o` only on the 4th beat; a single `done_o`.
- Operands pushed while IDLE until every FIFO is full → `store_op_ready_o=0` for all lanes and `beat_valid_o=0`; after the request, 2 beats drain and ready returns.
- `beat_ready_i` held low 5 cycles with `beat_valid_o=1` → `beat_o` and `beat_last_o` stable throughout; no FIFO pops.
- Reset asserted after 2 of 4 beats → next cycle IDLE, FIFOs empty, `done_o` stays 0; a following len=0 request completes normally.
- Back-to-back requests (len=1 then len=0, IDs 5 then 6) with continuous operands → `done_id_o`=5 then 6, and the second request is accepted the cycle after the first `done_o`-triggering handshake.
